// File: rtl/shift_add_multiplier_24bit_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_24bit_pkg
// Shared arithmetic-unit definitions used by the sequential multiplier and the
// restoring divider, so both blocks present the same start/busy/done control.
//   state_t        : IDLE / OPERATE / DONE FSM encoding (2 bits)
//   DEFAULT_WIDTH  : default operand width (24)
//   count_width()  : bits needed to hold an iteration count of 0..width
// -----------------------------------------------------------------------------
package shift_add_multiplier_24bit_pkg;

    localparam int DEFAULT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPERATE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // The counter is loaded with width itself, so it needs width+1 codes.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_add_shift_step.sv
// -----------------------------------------------------------------------------
// mult_add_shift_step
// One radix-2 shift-and-add iteration. If the accumulator LSB (current
// multiplier bit) is set, the multiplicand is added into the upper half; the
// full (2W+1)-bit result is then shifted right by one.
// Ports:
//   acc      in   2*WIDTH+1  current accumulator {carry, upper, multiplier bits}
//   mcand    in   WIDTH      multiplicand
//   acc_next out  2*WIDTH+1  accumulator after this step
// -----------------------------------------------------------------------------
module mult_add_shift_step #(
    parameter int WIDTH = 24
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  mcand,
    output logic [2*WIDTH:0]  acc_next
);

    logic [WIDTH:0] upper_sum;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        upper_sum = acc[2*WIDTH:WIDTH];
        if (acc[0]) begin
            // Upper field's MSB is always 0 before the add (it was shifted in),
            // so the (WIDTH+1)-bit sum cannot overflow.
            upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
        acc_next = {1'b0, upper_sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_add_multiplier_24bit.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_24bit
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Fixed latency of WIDTH+2 edges from the accepting edge to done.
// Ports:
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high
//   start         in   1        request, honoured only in IDLE
//   multiplicand  in   WIDTH    operand A, captured on the accepting edge
//   multiplier    in   WIDTH    operand B, captured on the accepting edge
//   product       out  2*WIDTH  A*B, held until the next completion
//   busy          out  1        high in OPERATE and DONE
//   done          out  1        one-cycle strobe with each new product
// -----------------------------------------------------------------------------
module shift_add_multiplier_24bit
    import shift_add_multiplier_24bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = count_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic [CW-1:0]      count;

    mult_add_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: every register, including the product, is cleared by reset; an
    // aborted operation must leave no stale result visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= {{(WIDTH+1){1'b0}}, multiplier};
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= OPERATE;
                    end
                end
                OPERATE: begin
                    // Always WIDTH iterations; no early exit on small operands.
                    if (count != '0) begin
                        acc   <= acc_next;
                        count <= count - CW'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    product <= acc[2*WIDTH-1:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_24bit.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier_24bit
// Scoreboard bench: expected products are queued when a request is driven and
// compared when done strobes. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier_24bit;

    localparam int W   = 24;
    localparam int LAT = W + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    multiplicand = '0;
    logic [W-1:0]    multiplier = '0;
    logic [2*W-1:0]  product;
    logic            busy;
    logic            done;

    logic [2*W-1:0]  exp_q[$];
    int              n_checks = 0;
    int              n_pass = 0;
    int              cyc = 0;

    shift_add_multiplier_24bit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive a request at a falling edge, pass the accepting edge, and stop at
    // the falling edge right after it. start stays high when hold is set.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        exp_q.push_back(48'(a) * 48'(b));
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called at the falling edge after the accepting edge. Counts edges until
    // done, optionally pulses a junk request at edge poke_at, then compares
    // latency, busy behaviour and the product against the scoreboard.
    task automatic wait_done(input string tag, input int poke_at, output int done_cyc);
        int lat = 0;
        bit busy_ok = 1'b1;
        done_cyc = -1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == poke_at) begin
                start        = 1'b1;
                multiplicand = 24'h123456;
                multiplier   = 24'h654321;
            end else if (poke_at >= 0 && lat == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            check({tag, "_product"}, 64'(product), 64'(exp_q.pop_front()));
        end
        done_cyc = cyc;
    endtask

    initial begin
        int t0, t1, dones;

        repeat (2) @(negedge clk);
        check("reset_product", 64'(product), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        multiplicand = 24'd3;
        multiplier = 24'd3;
        @(negedge clk);
        check("reset_vs_start_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        start = 1'b0;

        start_op(24'd3, 24'd5, 1'b0);
        wait_done("3x5", -1, t0);
        @(negedge clk);
        check("3x5_done_one_cycle", 64'(done), 64'd0);
        check("3x5_product_hold", 64'(product), 64'h00000000000F);

        start_op(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        wait_done("max", -1, t0);

        start_op(24'h000000, 24'hABCDEF, 1'b0);
        wait_done("zero", -1, t0);

        start_op(24'hABCDEF, 24'h000001, 1'b0);
        wait_done("one", -1, t0);

        // Second request at cycle 10 of the operation must be ignored.
        start_op(24'h001000, 24'h000200, 1'b0);
        wait_done("ignore", 10, t0);
        @(negedge clk);
        check("ignore_no_restart", 64'(busy), 64'd0);

        // Reset at cycle 12 aborts: outputs clear and no strobe follows.
        start_op(24'h00ABCD, 24'h000777, 1'b0);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_product", 64'(product), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_strobe", 64'(dones), 64'd0);

        start_op(24'd7, 24'd9, 1'b0);
        wait_done("7x9", -1, t0);

        // Back-to-back with start held high the whole time.
        start_op(24'd2, 24'd3, 1'b1);
        wait_done("b2b_first", -1, t0);
        multiplicand = 24'd4;
        multiplier   = 24'd5;
        exp_q.push_back(48'h14);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", -1, t1);
        check("b2b_spacing", 64'(t1 - t0), 64'(W + 3));
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
